// File: rtl/iir_mac_param.sv
// iir_mac_param: run-time programmable direct-form-I IIR filter.
// One signed MAC is time-multiplexed over the N+1 feed-forward and N
// feedback taps; each sample takes 2*ORDER+4 cycles (RD, CAP, MAC x(2N+1), WR).
// Optional feature macro: IIR_MAC_SAT_EN (saturate output and flag ovf);
// when undefined the output wraps and ovf stays 0.
//
// Handshake: load pulses one cycle with RAddr valid; DIn/data_done are
// sampled in the following (capture) cycle. WEN pulses one cycle per sample
// with WAddr/Yn valid in that same cycle. start is a one-cycle pulse honoured
// only while busy=0.
module iir_mac_param #(
  parameter int ORDER = 5,
  parameter int DW    = 16,
  parameter int CW    = 18,
  parameter int CFRAC = 14,
  parameter int AW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_we,
  input  logic          coef_sel,
  input  logic [3:0]    coef_idx,
  input  logic [CW-1:0] coef_data,
  input  logic          start,
  output logic          busy,
  output logic          load,
  output logic [AW-1:0] RAddr,
  input  logic [DW-1:0] DIn,
  input  logic          data_done,
  output logic          WEN,
  output logic [AW-1:0] WAddr,
  output logic [DW-1:0] Yn,
  output logic          Finish,
  output logic          ovf,
  output logic [2:0]    dbg_state_o
);

  localparam int ACCW   = DW + CW + 5;
  localparam int LAST_T = 2 * ORDER;
  localparam logic signed [ACCW-1:0] RND = {{(ACCW-1){1'b0}}, 1'b1} << (CFRAC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_MAC  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic signed [CW-1:0]   b_q [0:ORDER];
  logic signed [CW-1:0]   a_q [1:ORDER];
  logic signed [DW-1:0]   x_q [0:ORDER];
  logic signed [DW-1:0]   y_q [1:ORDER];
  logic signed [ACCW-1:0] acc_q;
  logic [4:0]             t_q;
  logic [AW-1:0]          raddr_q;
  logic [AW-1:0]          waddr_q;
  logic                   ovf_q;

  logic signed [CW-1:0]      coef_m;
  logic signed [DW-1:0]      samp_m;
  logic                      sub_m;
  logic signed [DW+CW-1:0]   prod_c;
  logic signed [ACCW-1:0]    prod_ext_c;
  logic signed [ACCW-1:0]    r_c;
  logic [DW-1:0]             yn_c;
  logic                      clip_c;
  logic                      busy_c;

  assign busy_c      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign busy        = busy_c;
  assign load        = (state_q == S_RD);
  assign WEN         = (state_q == S_WR);
  assign Finish      = (state_q == S_DONE);
  assign RAddr       = raddr_q;
  assign WAddr       = waddr_q;
  assign Yn          = (state_q == S_WR) ? yn_c : '0;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing: read, capture, walk the taps, write, repeat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RD;
      S_RD:           state_d = S_CAP;
      S_CAP:          state_d = data_done ? S_DONE : S_MAC;
      S_MAC:          if (t_q == 5'(LAST_T)) state_d = S_WR;
      S_WR:           state_d = S_RD;
      default:        state_d = S_IDLE;
    endcase
  end

  // Tap multiplexer: t <= ORDER reads b/x, above ORDER reads a/y and subtracts.
  always_comb begin
    coef_m = '0;
    samp_m = '0;
    sub_m  = 1'b0;
    for (int k = 0; k <= ORDER; k++) begin
      if (t_q == 5'(k)) begin
        coef_m = b_q[k];
        samp_m = x_q[k];
      end
    end
    for (int k = 1; k <= ORDER; k++) begin
      if (t_q == 5'(ORDER + k)) begin
        coef_m = a_q[k];
        samp_m = y_q[k];
        sub_m  = 1'b1;
      end
    end
  end

  assign prod_c     = coef_m * samp_m;
  assign prod_ext_c = {{5{prod_c[DW+CW-1]}}, prod_c};
  assign r_c        = (acc_q + RND) >>> CFRAC;

`ifdef IIR_MAC_SAT_EN
  localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Clamp the rounded result to the output range and flag the clip.
  always_comb begin
    yn_c   = r_c[DW-1:0];
    clip_c = 1'b0;
    if (r_c > YMAX) begin
      yn_c   = {1'b0, {(DW-1){1'b1}}};
      clip_c = 1'b1;
    end else if (r_c < YMIN) begin
      yn_c   = {1'b1, {(DW-1){1'b0}}};
      clip_c = 1'b1;
    end
  end
`else
  logic unused_r_hi;
  assign unused_r_hi = ^r_c[ACCW-1:DW];
  assign yn_c        = r_c[DW-1:0];
  assign clip_c      = 1'b0;
`endif

  // Datapath: coefficient bank, histories, accumulator, tap counter, addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= ORDER; k++) begin
        b_q[k] <= '0;
        x_q[k] <= '0;
      end
      for (int k = 1; k <= ORDER; k++) begin
        a_q[k] <= '0;
        y_q[k] <= '0;
      end
      acc_q   <= '0;
      t_q     <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // Coefficients are frozen during a run; a0 and out-of-range taps never match.
      if (coef_we && !busy_c) begin
        if (!coef_sel) begin
          for (int k = 0; k <= ORDER; k++)
            if (coef_idx == 4'(k)) b_q[k] <= coef_data;
        end else begin
          for (int k = 1; k <= ORDER; k++)
            if (coef_idx == 4'(k)) a_q[k] <= coef_data;
        end
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int k = 0; k <= ORDER; k++) x_q[k] <= '0;
            for (int k = 1; k <= ORDER; k++) y_q[k] <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        S_CAP: begin
          if (!data_done) begin
            x_q[0] <= DIn;
            for (int k = 1; k <= ORDER; k++) x_q[k] <= x_q[k-1];
            acc_q <= '0;
            t_q   <= '0;
          end
        end
        S_MAC: begin
          acc_q <= sub_m ? (acc_q - prod_ext_c) : (acc_q + prod_ext_c);
          t_q   <= t_q + 5'd1;
        end
        S_WR: begin
          // Feedback uses the narrowed output so the loop is bit-exact.
          y_q[1] <= yn_c;
          for (int k = 2; k <= ORDER; k++) y_q[k] <= y_q[k-1];
          raddr_q <= raddr_q + 1'b1;
          waddr_q <= waddr_q + 1'b1;
          if (clip_c) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mac_param.sv
// Testbench for iir_mac_param (ORDER=5, DW=16, CW=18, CFRAC=14, AW=20).
module tb_iir_mac_param;

  localparam int N     = 5;
  localparam int DW    = 16;
  localparam int CW    = 18;
  localparam int AW    = 20;
  localparam int SPACE = 2 * N + 4;

  logic          clk;
  logic          rst;
  logic          coef_we;
  logic          coef_sel;
  logic [3:0]    coef_idx;
  logic [CW-1:0] coef_data;
  logic          start;
  logic          busy;
  logic          load;
  logic [AW-1:0] RAddr;
  logic [DW-1:0] DIn;
  logic          data_done;
  logic          WEN;
  logic [AW-1:0] WAddr;
  logic [DW-1:0] Yn;
  logic          Finish;
  logic          ovf;
  logic [2:0]    dbg_state;

  iir_mac_param #(.ORDER(N), .DW(DW), .CW(CW), .CFRAC(14), .AW(AW)) dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_sel(coef_sel),
    .coef_idx(coef_idx), .coef_data(coef_data), .start(start), .busy(busy),
    .load(load), .RAddr(RAddr), .DIn(DIn), .data_done(data_done), .WEN(WEN),
    .WAddr(WAddr), .Yn(Yn), .Finish(Finish), .ovf(ovf), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters, scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] got_q[$];
  int            wen_cyc[$];
  int            wen_cnt = 0;
  int            start_cyc = 0;
  int            fin_cyc = 0;

  // sample memory
  logic signed [DW-1:0] smem [0:63];
  int n_smp = 0;

  // model copy of coefficients
  longint cb [0:N];
  longint ca [1:N];

  // Sample-memory responder: answers a load with DIn/data_done for the capture cycle.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      if (int'(RAddr) < n_smp) begin
        DIn = smem[RAddr[5:0]];
        data_done = 1'b0;
      end else begin
        DIn = '0;
        data_done = 1'b1;
      end
    end
  end

  // Result monitor: every write is checked against the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && WEN === 1'b1) begin
      logic [DW-1:0] e;
      logic [AW-1:0] ea;
      wen_cnt++;
      wen_cyc.push_back(cyc);
      got_q.push_back(Yn);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: Yn=%0d WAddr=%0d, required no write", $signed(Yn), WAddr);
      end else begin
        e  = exp_q.pop_front();
        ea = exp_addr_q.pop_front();
        if (Yn !== e || WAddr !== ea) begin
          n_err++;
          $display("FAIL yn_write: Yn=%0d WAddr=%0d, required Yn=%0d WAddr=%0d",
                   $signed(Yn), WAddr, $signed(e), ea);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    wen_cnt = 0;
    wen_cyc.delete();
    got_q.delete();
  endtask

  task automatic write_coef(input logic sel, input int idx, input int val, input bit accepted);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_sel  = sel;
    coef_idx  = 4'(idx);
    coef_data = CW'(val);
    @(negedge clk);
    coef_we   = 1'b0;
    if (accepted) begin
      if (!sel) cb[idx] = longint'(val);
      else      ca[idx] = longint'(val);
    end
  endtask

  task automatic zero_coefs();
    for (int k = 0; k <= N; k++) write_coef(1'b0, k, 0, 1'b1);
    for (int k = 1; k <= N; k++) write_coef(1'b1, k, 0, 1'b1);
  endtask

  task automatic push_exp(input int val, input int addr);
    exp_q.push_back(DW'(val));
    exp_addr_q.push_back(AW'(addr));
  endtask

  function automatic logic [DW-1:0] narrow(input longint acc);
    longint r;
    r = (acc + 64'sd8192) >>> 14;
`ifdef IIR_MAC_SAT_EN
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
`endif
    return r[15:0];
  endfunction

  // Reference direct-form-I model over smem[0..n-1]; pushes expected outputs.
  task automatic model_run(input int n);
    longint xh [0:N];
    longint yh [1:N];
    longint acc;
    logic [DW-1:0] y;
    for (int k = 0; k <= N; k++) xh[k] = 0;
    for (int k = 1; k <= N; k++) yh[k] = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = N; k > 0; k--) xh[k] = xh[k-1];
      xh[0] = longint'(smem[i]);
      acc = 0;
      for (int k = 0; k <= N; k++) acc += cb[k] * xh[k];
      for (int k = 1; k <= N; k++) acc -= ca[k] * yh[k];
      y = narrow(acc);
      push_exp(int'($signed(y)), i);
      for (int k = N; k > 1; k--) yh[k] = yh[k-1];
      yh[1] = longint'($signed(y));
    end
  endtask

  task automatic start_run();
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int max_cyc);
    int k;
    k = 0;
    while (Finish !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    fin_cyc = cyc;
    n_vec++;
    if (Finish !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: Finish=%b after %0d cycles, required 1", name, Finish, k);
    end
    @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d writes missing, required 0", name, exp_q.size());
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int k;
    int seen;
    // idle reset values
    repeat (2) @(negedge clk);
    n_vec++;
    if ({load, WEN, Finish, busy, ovf} !== 5'b0 || RAddr !== '0 || WAddr !== '0 || Yn !== '0) begin
      n_err++;
      $display("FAIL reset_idle: ctl=%b RAddr=%0d WAddr=%0d Yn=%0d, required all 0",
               {load, WEN, Finish, busy, ovf}, RAddr, WAddr, Yn);
    end
    rst = 1'b0;
    for (int i = 0; i <= N; i++) cb[i] = 0;
    for (int i = 1; i <= N; i++) ca[i] = 0;
    // start a run, interrupt it in the RD cycle after the second write
    write_coef(1'b0, 0, 16384, 1'b1);
    n_smp = 8;
    for (int i = 0; i < 8; i++) smem[i] = 16'sd500;
    for (int i = 0; i < 8; i++) push_exp(500, i);
    start_run();
    k = 0;
    seen = 0;
    while (seen < 2 && k < 200) begin
      @(posedge clk);
      #1;
      if (WEN === 1'b1) seen++;
      k++;
    end
    @(posedge clk);
    #2;
    n_vec++;
    if (load !== 1'b1 || RAddr !== AW'(2) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_state: load=%b RAddr=%0d busy=%b, required 1 2 1", load, RAddr, busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({load, WEN, Finish, busy, ovf} !== 5'b0 || RAddr !== '0 || WAddr !== '0 || Yn !== '0) begin
      n_err++;
      $display("FAIL reset_midrun: ctl=%b RAddr=%0d WAddr=%0d Yn=%0d, required all 0",
               {load, WEN, Finish, busy, ovf}, RAddr, WAddr, Yn);
    end
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= N; i++) cb[i] = 0;
    // coefficients are gone: an impulse now produces zeros
    n_smp = 2;
    smem[0] = 16'sd16384;
    smem[1] = 16'sd0;
    push_exp(0, 0);
    push_exp(0, 1);
    start_run();
    wait_finish("post_reset", 200);
    check_drained("post_reset");
  endtask

  task automatic test_pass_through();
    write_coef(1'b0, 0, 16384, 1'b1);
    n_smp = 3;
    smem[0] = 16'sd100;
    smem[1] = -16'sd200;
    smem[2] = 16'sd32767;
    push_exp(100, 0);
    push_exp(-200, 1);
    push_exp(32767, 2);
    start_run();
    wait_finish("pass", 200);
    check_drained("pass");
    n_vec++;
    if (wen_cnt != 3) begin
      n_err++;
      $display("FAIL pass_wen_count: %0d, required 3", wen_cnt);
    end else begin
      n_vec++;
      if (wen_cyc[0] - start_cyc != SPACE) begin
        n_err++;
        $display("FAIL pass_first_latency: %0d, required %0d", wen_cyc[0] - start_cyc, SPACE);
      end
      n_vec++;
      if (wen_cyc[1] - wen_cyc[0] != SPACE || wen_cyc[2] - wen_cyc[1] != SPACE) begin
        n_err++;
        $display("FAIL pass_spacing: %0d %0d, required %0d", wen_cyc[1] - wen_cyc[0],
                 wen_cyc[2] - wen_cyc[1], SPACE);
      end
      n_vec++;
      if (fin_cyc - wen_cyc[2] != 3) begin
        n_err++;
        $display("FAIL pass_finish_timing: %0d cycles after last write, required 3", fin_cyc - wen_cyc[2]);
      end
    end
    n_vec++;
    if (busy !== 1'b0 || Finish !== 1'b1) begin
      n_err++;
      $display("FAIL pass_done_flags: busy=%b Finish=%b, required 0 1", busy, Finish);
    end
  endtask

  task automatic test_single_pole();
    write_coef(1'b0, 0, 8192, 1'b1);
    write_coef(1'b1, 1, -8192, 1'b1);
    n_smp = 6;
    smem[0] = 16'sd16384;
    for (int i = 1; i < 6; i++) smem[i] = 16'sd0;
    push_exp(8192, 0);
    push_exp(4096, 1);
    push_exp(2048, 2);
    push_exp(1024, 3);
    push_exp(512, 4);
    push_exp(256, 5);
    start_run();
    wait_finish("pole", 300);
    check_drained("pole");
    write_coef(1'b1, 1, 0, 1'b1);
  endtask

  task automatic test_overflow();
    write_coef(1'b0, 0, 32768, 1'b1);
    n_smp = 2;
    smem[0] = 16'sd32767;
    smem[1] = -16'sd32768;
`ifdef IIR_MAC_SAT_EN
    push_exp(32767, 0);
    push_exp(-32768, 1);
`else
    push_exp(-2, 0);
    push_exp(0, 1);
`endif
    start_run();
    wait_finish("ovf", 200);
    check_drained("ovf");
    n_vec++;
`ifdef IIR_MAC_SAT_EN
    if (ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: %b, required 1", ovf);
    end
`else
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_flag: %b, required 0", ovf);
    end
`endif
  endtask

  task automatic test_lock_empty();
    write_coef(1'b0, 0, 16384, 1'b1);
    write_coef(1'b1, 0, 12345, 1'b0);
    write_coef(1'b0, 6, 12345, 1'b0);
    n_smp = 6;
    for (int i = 0; i < 6; i++) smem[i] = DW'(1000 + 37 * i);
    model_run(6);
    start_run();
    repeat (20) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL lock_busy: %b, required 1", busy);
    end
    write_coef(1'b0, 0, 0, 1'b0);
    wait_finish("lock", 300);
    check_drained("lock");
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_cleared: %b, required 0", ovf);
    end
    // empty run
    n_smp = 0;
    start_run();
    wait_finish("empty", 50);
    n_vec++;
    if (wen_cnt != 0 || fin_cyc - start_cyc != 3) begin
      n_err++;
      $display("FAIL empty_run: writes=%0d finish_after=%0d, required 0 3", wen_cnt, fin_cyc - start_cyc);
    end
    check_drained("empty");
  endtask

  task automatic test_restart();
    logic [DW-1:0] first[$];
    for (int k = 0; k <= N; k++) write_coef(1'b0, k, $urandom_range(16383) - 8192, 1'b1);
    for (int k = 1; k <= N; k++) write_coef(1'b1, k, $urandom_range(8191) - 4096, 1'b1);
    n_smp = 12;
    for (int i = 0; i < 12; i++) smem[i] = DW'(int'($urandom_range(40000)) - 20000);
    model_run(12);
    start_run();
    wait_finish("restart1", 400);
    check_drained("restart1");
    first = got_q;
    model_run(12);
    start_run();
    wait_finish("restart2", 400);
    check_drained("restart2");
    n_vec++;
    if (got_q.size() != 12 || first.size() != 12) begin
      n_err++;
      $display("FAIL restart_count: %0d %0d, required 12 12", first.size(), got_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_vec++;
        if (got_q[i] !== first[i]) begin
          n_err++;
          $display("FAIL restart_repeat[%0d]: %0d, required %0d", i, $signed(got_q[i]), $signed(first[i]));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    coef_we = 1'b0;
    coef_sel = 1'b0;
    coef_idx = '0;
    coef_data = '0;
    start = 1'b0;
    DIn = '0;
    data_done = 1'b0;
    test_reset();
    zero_coefs();
    test_pass_through();
    test_single_pole();
    test_overflow();
    test_lock_empty();
    zero_coefs();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
